// File: rtl/turfio_mode1_arbiter_if.sv
// MODE1 byte-stream bundle: NSRC AXI4-Stream byte sources in, one registered stream out.
// master = requester/splicer side, slave = arbiter side.
interface turfio_mode1_arbiter_if #(
  parameter int unsigned NSRC = 3
);
  logic [NSRC*8-1:0] s_tdata;
  logic [NSRC*2-1:0] s_tuser;
  logic [NSRC*3-1:0] s_tdest;
  logic [NSRC-1:0]   s_tlast;
  logic [NSRC-1:0]   s_tvalid;
  logic [NSRC-1:0]   s_tready;
  logic [7:0]        m_tdata;
  logic [1:0]        m_tuser;
  logic [2:0]        m_tdest;
  logic              m_tvalid;
  logic              m_tready;

  modport master (
    output s_tdata, s_tuser, s_tdest, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tuser, m_tdest, m_tvalid,
    output m_tready
  );

  modport slave (
    input  s_tdata, s_tuser, s_tdest, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tuser, m_tdest, m_tvalid,
    input  m_tready
  );
endinterface

// File: rtl/turfio_mode1_arbiter.sv
// Round-robin, packet-locked arbiter sharing the TURFIO MODE1 splicer channel between NSRC sources.
// Optional per-source packet counters are built when MODE1_ARB_STATS_EN is defined.
module turfio_mode1_arbiter #(
  parameter int unsigned NSRC    = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  sysclk_i,
  input  logic                  rst_i,
  turfio_mode1_arbiter_if.slave bus,
  input  logic [NSRC-1:0]       enable_i,
  output logic [NSRC-1:0]       grant_o,
  output logic                  timeout_o
`ifdef MODE1_ARB_STATS_EN
  ,
  input  logic                  stat_clr_i,
  output logic [NSRC*16-1:0]    stat_pkts_o
`endif
);

  localparam int unsigned IdxW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
  logic            m_tvalid_q, m_tvalid_d;
  logic [7:0]      m_tdata_q, m_tdata_d;
  logic [1:0]      m_tuser_q, m_tuser_d;
  logic [2:0]      m_tdest_q, m_tdest_d;

  logic            sel_valid, sel_last;
  logic [7:0]      sel_data;
  logic [1:0]      sel_user;
  logic [2:0]      sel_dest;
  logic [NSRC-1:0] req;
  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic            accept, stall;
  logic [NSRC-1:0] s_ready;

  assign req = bus.s_tvalid & enable_i;

  // Fields of the currently locked source.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    sel_dest  = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (gidx_q == IdxW'(k)) begin
        sel_valid = bus.s_tvalid[k];
        sel_last  = bus.s_tlast[k];
        sel_data  = bus.s_tdata[8*k +: 8];
        sel_user  = bus.s_tuser[2*k +: 2];
        sel_dest  = bus.s_tdest[3*k +: 3];
      end
    end
  end

  // First requester after the previous owner, wrapping; the previous owner is checked last.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 1; off <= NSRC; off++) begin
      cand     = (32'(last_q) + off) % NSRC;
      cand_idx = IdxW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign accept = (state_q == StLocked) && sel_valid && (!m_tvalid_q || bus.m_tready);
  assign stall  = m_tvalid_q && !bus.m_tready;

  always_comb begin
    s_ready = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (accept && gidx_q == IdxW'(k)) s_ready[k] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    grant_d    = grant_q;
    tcnt_d     = tcnt_q;
    timeout_d  = 1'b0;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tdest_d  = m_tdest_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StLocked;
          gidx_d  = win_idx;
          grant_d = {{(NSRC-1){1'b0}}, 1'b1} << win_idx;
          tcnt_d  = '0;
        end
      end
      StLocked: begin
        if (accept) begin
          tcnt_d = '0;
          if (sel_last) begin
            state_d = StIdle;
            last_d  = gidx_q;
            grant_d = '0;
          end
        end else if (!sel_valid && !stall) begin
          // Owner has gone quiet mid-packet; give the channel away after TIMEOUT idle cycles.
          if (tcnt_q == 16'(TIMEOUT - 1)) begin
            state_d   = StIdle;
            last_d    = gidx_q;
            grant_d   = '0;
            timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = sel_data;
      m_tuser_d  = sel_user;
      m_tdest_d  = sel_dest;
    end else if (bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gidx_q     <= '0;
      last_q     <= IdxW'(NSRC - 1);
      grant_q    <= '0;
      tcnt_q     <= '0;
      timeout_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tdest_q  <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tcnt_q     <= tcnt_d;
      timeout_q  <= timeout_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tdest_q  <= m_tdest_d;
    end
  end

  assign bus.s_tready = s_ready;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tdest  = m_tdest_q;
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;

`ifdef MODE1_ARB_STATS_EN
  logic [NSRC-1:0][15:0] stat_q, stat_d;

  // Only packets closed by tlast count; clear wins over a same-cycle increment.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr_i) begin
      stat_d = '0;
    end else if (accept && sel_last) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (gidx_q == IdxW'(k) && stat_q[k] != 16'hFFFF) stat_d[k] = stat_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_pkts_o = stat_q;
`else
  // No packet statistics in this build.
`endif

endmodule

// File: tb/tb_turfio_mode1_arbiter.sv
// Self-checking bench for turfio_mode1_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_turfio_mode1_arbiter;
  localparam int unsigned NSRC    = 3;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] en;
  logic [NSRC-1:0] grant;
  logic            tout;
  logic            mrdy;
  logic            sclr;
`ifdef MODE1_ARB_STATS_EN
  logic [NSRC-1:0][15:0] stats;
`endif

  always #5 clk = ~clk;

  turfio_mode1_arbiter_if #(.NSRC(NSRC)) bif ();

  turfio_mode1_arbiter #(
    .NSRC   (NSRC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sysclk_i (clk),
    .rst_i    (rst),
    .bus      (bif.slave),
    .enable_i (en),
    .grant_o  (grant),
    .timeout_o(tout)
`ifdef MODE1_ARB_STATS_EN
    ,
    .stat_clr_i (sclr),
    .stat_pkts_o(stats)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] u;
    logic [2:0] t;
    logic       l;
    int         gap;
  } beat_t;

  beat_t srcq[NSRC][$];
  int    wt[NSRC];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: owner index (-1 = nobody), last owner, idle-cycle run length, output reg.
  int         m_own, m_last, m_idle;
  logic       m_ov, m_to;
  logic [7:0] m_d;
  logic [1:0] m_u;
  logic [2:0] m_t;
  int         m_stat[NSRC];

  logic [7:0]      out_log[$];
  logic [NSRC-1:0] gnt_log[$];
  logic [NSRC-1:0] prev_g;
  int              v_cyc, mv_cyc, tout_cyc;
  int              acc_cyc[NSRC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit present(input int k);
    return srcq[k].size() != 0 && wt[k] == 0;
  endfunction

  task automatic push(input int k, input logic [7:0] d, input logic [1:0] u, input logic [2:0] t,
                      input logic l, input int gap);
    beat_t b;
    b.d = d; b.u = u; b.t = t; b.l = l; b.gap = gap;
    if (srcq[k].size() == 0) wt[k] = gap;
    srcq[k].push_back(b);
  endtask

  task automatic drive();
    logic [NSRC-1:0]       tv, tl;
    logic [NSRC-1:0][7:0]  td;
    logic [NSRC-1:0][1:0]  tu;
    logic [NSRC-1:0][2:0]  tt;
    tv = '0; tl = '0; td = '0; tu = '0; tt = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (present(k)) begin
        tv[k] = 1'b1;
        tl[k] = srcq[k][0].l;
        td[k] = srcq[k][0].d;
        tu[k] = srcq[k][0].u;
        tt[k] = srcq[k][0].t;
      end
    end
    bif.s_tvalid = tv;
    bif.s_tlast  = tl;
    bif.s_tdata  = td;
    bif.s_tuser  = tu;
    bif.s_tdest  = tt;
    bif.m_tready = mrdy;
  endtask

  task automatic model_reset();
    m_own = -1; m_last = NSRC - 1; m_idle = 0;
    m_ov = 1'b0; m_to = 1'b0; m_d = '0; m_u = '0; m_t = '0;
    for (int k = 0; k < NSRC; k++) m_stat[k] = 0;
  endtask

  function automatic logic [NSRC-1:0] model_ready();
    logic [NSRC-1:0] r;
    r = '0;
    if (m_own >= 0 && present(m_own) && (!m_ov || mrdy)) r[m_own] = 1'b1;
    return r;
  endfunction

  function automatic logic [NSRC-1:0] model_grant();
    logic [NSRC-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_update();
    logic [NSRC-1:0] rd;
    int              c;
    rd = model_ready();
    if (rst) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (m_own < 0) begin
      for (int off = 1; off <= NSRC; off++) begin
        c = (m_last + off) % NSRC;
        if (m_own < 0 && present(c) && en[c]) begin
          m_own  = c;
          m_idle = 0;
        end
      end
    end else if (rd != 0) begin
      m_d = srcq[m_own][0].d;
      m_u = srcq[m_own][0].u;
      m_t = srcq[m_own][0].t;
      m_idle = 0;
      if (srcq[m_own][0].l) begin
        if (m_stat[m_own] < 65535) m_stat[m_own]++;
        m_last = m_own;
        m_own  = -1;
      end
    end else if (!present(m_own) && !(m_ov && !mrdy)) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_to   = 1'b1;
        m_last = m_own;
        m_own  = -1;
      end
    end
    if (rd != 0)   m_ov = 1'b1;
    else if (mrdy) m_ov = 1'b0;
    if (sclr) for (int k = 0; k < NSRC; k++) m_stat[k] = 0;
  endtask

  task automatic source_update(input logic [NSRC-1:0] rd);
    for (int k = 0; k < NSRC; k++) begin
      if (rd[k]) begin
        void'(srcq[k].pop_front());
        wt[k] = (srcq[k].size() != 0) ? srcq[k][0].gap : 0;
      end else if (wt[k] > 0 && srcq[k].size() != 0) begin
        wt[k]--;
      end
    end
  endtask

  task automatic cycle();
    logic [NSRC-1:0] rd;
    int              cur;
    drive();
    @(negedge clk);
    cur = cyc;
    rd  = model_ready();
    check("grant", grant, model_grant());
    check("s_tready", bif.s_tready, rd);
    check("m_tvalid", bif.m_tvalid, m_ov);
    check("m_tdata", bif.m_tdata, m_d);
    check("m_tuser", bif.m_tuser, m_u);
    check("m_tdest", bif.m_tdest, m_t);
    check("timeout", tout, m_to);
`ifdef MODE1_ARB_STATS_EN
    for (int k = 0; k < NSRC; k++) check("stat", stats[k], m_stat[k]);
`endif
    if (bif.m_tvalid && mrdy) out_log.push_back(bif.m_tdata);
    if (grant != 0 && prev_g == 0) gnt_log.push_back(grant);
    prev_g = grant;
    if (v_cyc < 0 && bif.s_tvalid != 0) v_cyc = cur;
    if (mv_cyc < 0 && bif.m_tvalid) mv_cyc = cur;
    if (tout && tout_cyc < 0) tout_cyc = cur;
    for (int k = 0; k < NSRC; k++) if (rd[k]) acc_cyc[k] = cur;
    @(posedge clk);
    cyc++;
    model_update();
    source_update(rd);
    #1;
    drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp3[3];
    int         a1;

    en = '1; mrdy = 1'b1; sclr = 1'b0; prev_g = '0;
    v_cyc = -1; mv_cyc = -1; tout_cyc = -1;
    for (int k = 0; k < NSRC; k++) begin wt[k] = 0; acc_cyc[k] = -1; end
    model_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // 1: three-beat packet from source 0, latency and ordering.
    out_log.delete(); v_cyc = -1; mv_cyc = -1;
    push(0, 8'hA1, 2'd1, 3'd4, 1'b0, 0);
    push(0, 8'hA2, 2'd1, 3'd4, 1'b0, 0);
    push(0, 8'hA3, 2'd1, 3'd4, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_log.size() >= 3 && grant == 0) break;
    end
    exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3;
    check("t1_count", out_log.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_byte", (i < out_log.size()) ? out_log[i] : 8'hxx, exp3[i]);
    check("t1_latency", mv_cyc - v_cyc, 2);
    check("t1_tuser", bif.m_tuser, 2'd1);
    check("t1_tdest", bif.m_tdest, 3'd4);
    check("t1_release", grant, 3'b000);

    // 2: sources 0 and 2 stream single-beat packets; source 1 requests but is masked.
    en = 3'b101; gnt_log.delete();
    push(1, 8'h10, 2'd0, 3'd0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      push(0, 8'h00 + 8'(i), 2'd2, 3'd1, 1'b1, 0);
      push(2, 8'h20 + 8'(i), 2'd3, 3'd2, 1'b1, 0);
    end
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (srcq[0].size() == 0 && srcq[2].size() == 0) break;
    end
    check("t2_grants", gnt_log.size(), 12);
    if (gnt_log.size() != 0) check("t2_first", gnt_log[0], 3'b100);
    for (int i = 1; i < gnt_log.size(); i++)
      check("t2_alternate", gnt_log[i], (gnt_log[i-1] == 3'b001) ? 3'b100 : 3'b001);
    check("t2_src1_pending", srcq[1].size(), 1);
    srcq[1].delete(); wt[1] = 0; en = '1;
    repeat (4) cycle();

    // 3: source 1 packet with output backpressure after the first beat.
    out_log.delete();
    push(1, 8'h31, 2'd0, 3'd3, 1'b0, 0);
    push(1, 8'h32, 2'd0, 3'd3, 1'b0, 0);
    push(1, 8'h33, 2'd0, 3'd3, 1'b1, 0);
    for (int i = 0; i < 20 && !bif.m_tvalid; i++) cycle();
    mrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_hold", bif.m_tdata, 8'h31);
      check("t3_no_ready", bif.s_tready[1], 1'b0);
    end
    mrdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (out_log.size() >= 3 && grant == 0) break;
    end
    exp3[0] = 8'h31; exp3[1] = 8'h32; exp3[2] = 8'h33;
    check("t3_count", out_log.size(), 3);
    for (int i = 0; i < 3; i++) check("t3_byte", (i < out_log.size()) ? out_log[i] : 8'hxx, exp3[i]);

    // 4: source 1 stalls mid-packet while source 2 waits; forced release after TIMEOUT idle cycles.
    tout_cyc = -1; acc_cyc[1] = -1;
    push(1, 8'h41, 2'd1, 3'd5, 1'b0, 0);
    for (int i = 0; i < 10 && grant != 3'b010; i++) cycle();
    push(2, 8'h42, 2'd1, 3'd6, 1'b1, 0);
    for (int i = 0; i < 40 && tout_cyc < 0; i++) cycle();
    a1 = acc_cyc[1];
    check("t4_timeout_delay", tout_cyc - a1, TIMEOUT + 1);
    check("t4_pulse_width", tout, 1'b0);
    check("t4_next_owner", grant, 3'b100);
    repeat (6) cycle();

    // 5: reset in the middle of a held source-2 packet.
    mrdy = 1'b0;
    push(2, 8'h51, 2'd0, 3'd7, 1'b0, 0);
    push(2, 8'h52, 2'd0, 3'd7, 1'b0, 0);
    push(2, 8'h53, 2'd0, 3'd7, 1'b1, 0);
    for (int i = 0; i < 10 && !(bif.m_tvalid && grant == 3'b100); i++) cycle();
    check("t5_pre_gnt", grant, 3'b100);
    rst = 1'b1;
    #1;
    check("t5_mvalid", bif.m_tvalid, 1'b0);
    check("t5_grant", grant, 3'b000);
    model_reset();
    for (int k = 0; k < NSRC; k++) begin srcq[k].delete(); wt[k] = 0; end
    mrdy = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    gnt_log.delete(); prev_g = '0;
    push(0, 8'h60, 2'd0, 3'd0, 1'b1, 0);
    push(2, 8'h62, 2'd0, 3'd2, 1'b1, 0);
    for (int i = 0; i < 10 && gnt_log.size() == 0; i++) cycle();
    check("t5_first_winner", (gnt_log.size() != 0) ? gnt_log[0] : 3'bxxx, 3'b001);
    repeat (8) cycle();

`ifdef MODE1_ARB_STATS_EN
    // 6: packet counters ignore timed-out packets; clear zeroes everything.
    sclr = 1'b1; cycle(); sclr = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 8'h70 + 8'(i), 2'd0, 3'd0, 1'b1, 0);
    push(1, 8'h71, 2'd0, 3'd1, 1'b0, 2);
    repeat (40) cycle();
    check("t6_src0", stats[0], 16'd3);
    check("t6_src1", stats[1], 16'd0);
    sclr = 1'b1; cycle(); sclr = 1'b0;
    for (int k = 0; k < NSRC; k++) check("t6_clear", stats[k], 16'd0);
`endif

    // Randomized traffic, gaps, backpressure, masking and counter clears.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 2) == 0) ? NSRC'($urandom_range(0, 7)) : '1;
      mrdy = ($urandom_range(0, 3) != 0);
      sclr = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NSRC; k++) begin
        if (srcq[k].size() < 3 && $urandom_range(0, 3) == 0)
          push(k, 8'($urandom), 2'($urandom), 3'($urandom), $urandom_range(0, 2) == 0,
               ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 2)));
      end
      cycle();
    end
    sclr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
